aixh_mxc_left_dwd_driver: RTL and testbench

AIXH_MXC_LEFT_DWD_DRIVER -- requirements
Module: AIXH_MXC_LEFT_dwd_driver

---
 rtl/aixh_mxc_left_dwd_driver_if.sv | 34 +++
 rtl/aixh_mxc_left_dwd_driver.sv | 167 ++++++++++++++++
 tb/tb_aixh_mxc_left_dwd_driver.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/aixh_mxc_left_dwd_driver_if.sv
// Request/downward bus bundle for the LEFT DWD driver.
// master = upstream producer and downstream observer; slave = the driver itself.
interface aixh_mxc_left_dwd_driver_if #(
   parameter int CW = 4,
   parameter int DW = 32
);
   logic          i_req_vld;
   logic          o_req_rdy;
   logic [CW-1:0] i_req_cmd;
   logic [DW-1:0] i_req_dat;
   logic [CW-1:0] o_dwd_cmd;
   logic          o_dwd_vld;
   logic [DW-1:0] o_dwd_dat;

   modport master (
      output i_req_vld,
      output i_req_cmd,
      output i_req_dat,
      input  o_req_rdy,
      input  o_dwd_cmd,
      input  o_dwd_vld,
      input  o_dwd_dat
   );

   modport slave (
      input  i_req_vld,
      input  i_req_cmd,
      input  i_req_dat,
      output o_req_rdy,
      output o_dwd_cmd,
      output o_dwd_vld,
      output o_dwd_dat
   );
endinterface

// File: rtl/aixh_mxc_left_dwd_driver.sv
// LEFT DWD driver: request FIFO feeding a paced IDLE/ISSUE/GAP issue FSM.
// Optional beat counter output enabled by AIXH_MXC_LEFT_DWD_DRV_BEATCNT_EN.
package aixh_mxc_left_dwd_pkg;
   localparam int LPCELL_DWD_CWIDTH = 4;
   localparam int LPCELL_DWD_DWIDTH = 32;
endpackage

module aixh_mxc_left_dwd_driver
   import aixh_mxc_left_dwd_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                             aixh_core_clk2x,
   input  logic                             aixh_core_rst2x,
   input  logic                             i_enable,
   input  logic                             i_flush,
   input  logic [3:0]                       i_gap,
   aixh_mxc_left_dwd_driver_if.slave        bus,
   output logic                             o_busy
`ifdef AIXH_MXC_LEFT_DWD_DRV_BEATCNT_EN
   ,
   output logic [15:0]                      o_beat_cnt
`endif
);
   localparam int CW = LPCELL_DWD_CWIDTH;
   localparam int DW = LPCELL_DWD_DWIDTH;
   localparam int AW = $clog2(DEPTH);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_GAP
   } state_t;

   logic [CW-1:0] r_mem_cmd [DEPTH];
   logic [DW-1:0] r_mem_dat [DEPTH];
   logic [AW:0]   r_wr_ptr;
   logic [AW:0]   r_rd_ptr;
   state_t        r_state;
   state_t        w_state_nxt;
   logic [3:0]    r_gap_cnt;
   logic [3:0]    w_gap_cnt_nxt;
   logic          w_empty;
   logic          w_full;
   logic          w_push;
   logic          w_pop;
   logic [CW-1:0] r_dwd_cmd;
   logic          r_dwd_vld;
   logic [DW-1:0] r_dwd_dat;

   // The extra pointer MSB separates the full and empty cases when the indices match.
   assign w_empty = (r_wr_ptr == r_rd_ptr);
   assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                    (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

   assign w_push = bus.i_req_vld && bus.o_req_rdy && !i_flush;
   assign w_pop  = (r_state == ST_ISSUE) && !w_empty && i_enable && !i_flush;

   assign bus.o_req_rdy = !w_full && !aixh_core_rst2x;
   assign o_busy        = !aixh_core_rst2x && (!w_empty || (r_state != ST_IDLE));

   assign bus.o_dwd_cmd = r_dwd_cmd;
   assign bus.o_dwd_vld = r_dwd_vld;
   assign bus.o_dwd_dat = r_dwd_dat;

   always_ff @(posedge aixh_core_clk2x) begin
      if (w_push) begin
         r_mem_cmd[r_wr_ptr[AW-1:0]] <= bus.i_req_cmd;
         r_mem_dat[r_wr_ptr[AW-1:0]] <= bus.i_req_dat;
      end
   end

   always_ff @(posedge aixh_core_clk2x) begin
      if (aixh_core_rst2x || i_flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
      end
   end

   always_ff @(posedge aixh_core_clk2x) begin
      if (aixh_core_rst2x) begin
         r_state   <= ST_IDLE;
         r_gap_cnt <= '0;
      end else begin
         r_state   <= w_state_nxt;
         r_gap_cnt <= w_gap_cnt_nxt;
      end
   end

   // The gap length is captured only on a pop, so changes to i_gap mid-GAP wait for the next beat.
   always_comb begin
      w_state_nxt   = r_state;
      w_gap_cnt_nxt = r_gap_cnt;
      if (i_flush) begin
         w_state_nxt   = ST_IDLE;
         w_gap_cnt_nxt = '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (!w_empty && i_enable) begin
                  w_state_nxt = ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               if (w_pop) begin
                  if (i_gap != 4'd0) begin
                     w_state_nxt   = ST_GAP;
                     w_gap_cnt_nxt = i_gap;
                  end
               end else begin
                  w_state_nxt = ST_IDLE;
               end
            end
            ST_GAP: begin
               if (r_gap_cnt <= 4'd1) begin
                  w_gap_cnt_nxt = '0;
                  w_state_nxt   = w_empty ? ST_IDLE : ST_ISSUE;
               end else begin
                  w_gap_cnt_nxt = r_gap_cnt - 4'd1;
               end
            end
            default: begin
               w_state_nxt   = ST_IDLE;
               w_gap_cnt_nxt = '0;
            end
         endcase
      end
   end

   // Data holds between beats so the downstream chain sees no toggling while invalid.
   always_ff @(posedge aixh_core_clk2x) begin
      if (aixh_core_rst2x) begin
         r_dwd_vld <= 1'b0;
         r_dwd_cmd <= '0;
         r_dwd_dat <= '0;
      end else if (w_pop) begin
         r_dwd_vld <= 1'b1;
         r_dwd_cmd <= r_mem_cmd[r_rd_ptr[AW-1:0]];
         r_dwd_dat <= r_mem_dat[r_rd_ptr[AW-1:0]];
      end else begin
         r_dwd_vld <= 1'b0;
         r_dwd_cmd <= '0;
      end
   end

`ifdef AIXH_MXC_LEFT_DWD_DRV_BEATCNT_EN
   logic [15:0] r_beat_cnt;

   always_ff @(posedge aixh_core_clk2x) begin
      if (aixh_core_rst2x || i_flush) begin
         r_beat_cnt <= '0;
      end else if (w_pop) begin
         r_beat_cnt <= r_beat_cnt + 16'd1;
      end
   end

   assign o_beat_cnt = r_beat_cnt;
`endif

endmodule

// File: tb/tb_aixh_mxc_left_dwd_driver.sv
// Directed self-checking bench for aixh_mxc_left_dwd_driver (DEPTH=4).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_aixh_mxc_left_dwd_driver;
   import aixh_mxc_left_dwd_pkg::*;

   localparam int CW = LPCELL_DWD_CWIDTH;
   localparam int DW = LPCELL_DWD_DWIDTH;

   logic       clock = 1'b0;
   logic       reset;
   logic       enable;
   logic       flush;
   logic [3:0] gap;
   logic       busy;
`ifdef AIXH_MXC_LEFT_DWD_DRV_BEATCNT_EN
   logic [15:0] beatCnt;
`endif

   int checks = 0;
   int errors = 0;

   always #5 clock = ~clock;

   aixh_mxc_left_dwd_driver_if #(.CW(CW), .DW(DW)) bus ();

   aixh_mxc_left_dwd_driver #(.DEPTH(4)) dut (
      .aixh_core_clk2x (clock),
      .aixh_core_rst2x (reset),
      .i_enable        (enable),
      .i_flush         (flush),
      .i_gap           (gap),
      .bus             (bus.slave),
      .o_busy          (busy)
`ifdef AIXH_MXC_LEFT_DWD_DRV_BEATCNT_EN
      ,
      .o_beat_cnt      (beatCnt)
`endif
   );

   // One rising edge, then settle to the falling edge for sampling and driving.
   task automatic step();
      @(posedge clock);
      @(negedge clock);
   endtask

   task automatic test_reset();
      reset = 1'b1;
      step();
      step();
      checks++; if (bus.o_dwd_vld !== 1'b0) begin errors++; $display("[TB] FAIL reset_vld: got %0b want 0", bus.o_dwd_vld); end
      checks++; if (bus.o_dwd_cmd !== 4'd0) begin errors++; $display("[TB] FAIL reset_cmd: got %0h want 0", bus.o_dwd_cmd); end
      checks++; if (bus.o_dwd_dat !== 32'd0) begin errors++; $display("[TB] FAIL reset_dat: got %0h want 0", bus.o_dwd_dat); end
      checks++; if (bus.o_req_rdy !== 1'b0) begin errors++; $display("[TB] FAIL reset_rdy: got %0b want 0", bus.o_req_rdy); end
      checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %0b want 0", busy); end
      reset = 1'b0;
      #1;
      checks++; if (bus.o_req_rdy !== 1'b1) begin errors++; $display("[TB] FAIL reset_release_rdy: got %0b want 1", bus.o_req_rdy); end
   endtask

   task automatic test_single();
      enable = 1'b1;
      gap = 4'd0;
      bus.i_req_vld = 1'b1;
      bus.i_req_cmd = 4'd3;
      bus.i_req_dat = 32'hA5;
      step();
      bus.i_req_vld = 1'b0;
      checks++; if (bus.o_dwd_vld !== 1'b0) begin errors++; $display("[TB] FAIL single_vld_e0: got %0b want 0", bus.o_dwd_vld); end
      checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL single_busy_e0: got %0b want 1", busy); end
      step();
      checks++; if (bus.o_dwd_vld !== 1'b0) begin errors++; $display("[TB] FAIL single_vld_e1: got %0b want 0", bus.o_dwd_vld); end
      step();
      checks++; if (bus.o_dwd_vld !== 1'b1) begin errors++; $display("[TB] FAIL single_vld_e2: got %0b want 1", bus.o_dwd_vld); end
      checks++; if (bus.o_dwd_cmd !== 4'd3) begin errors++; $display("[TB] FAIL single_cmd_e2: got %0h want 3", bus.o_dwd_cmd); end
      checks++; if (bus.o_dwd_dat !== 32'hA5) begin errors++; $display("[TB] FAIL single_dat_e2: got %0h want a5", bus.o_dwd_dat); end
      step();
      checks++; if (bus.o_dwd_vld !== 1'b0) begin errors++; $display("[TB] FAIL single_vld_e3: got %0b want 0", bus.o_dwd_vld); end
      checks++; if (bus.o_dwd_cmd !== 4'd0) begin errors++; $display("[TB] FAIL single_cmd_e3: got %0h want 0", bus.o_dwd_cmd); end
      checks++; if (bus.o_dwd_dat !== 32'hA5) begin errors++; $display("[TB] FAIL single_dat_hold_e3: got %0h want a5", bus.o_dwd_dat); end
      checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL single_busy_e3: got %0b want 0", busy); end
   endtask

   task automatic test_fill();
      enable = 1'b0;
      gap = 4'd0;
      for (int i = 0; i < 4; i++) begin
         bus.i_req_vld = 1'b1;
         bus.i_req_cmd = 4'(i + 1);
         bus.i_req_dat = 32'h10 + 32'(i);
         step();
      end
      checks++; if (bus.o_req_rdy !== 1'b0) begin errors++; $display("[TB] FAIL fill_rdy_full: got %0b want 0", bus.o_req_rdy); end
      bus.i_req_cmd = 4'd5;
      bus.i_req_dat = 32'hEE;
      step();
      checks++; if (bus.o_req_rdy !== 1'b0) begin errors++; $display("[TB] FAIL fill_rdy_5th: got %0b want 0", bus.o_req_rdy); end
      bus.i_req_vld = 1'b0;
      enable = 1'b1;
      step();
      checks++; if (bus.o_dwd_vld !== 1'b0) begin errors++; $display("[TB] FAIL fill_vld_wake: got %0b want 0", bus.o_dwd_vld); end
      for (int i = 0; i < 4; i++) begin
         step();
         checks++; if (bus.o_dwd_vld !== 1'b1) begin errors++; $display("[TB] FAIL fill_vld_beat%0d: got %0b want 1", i, bus.o_dwd_vld); end
         checks++; if (bus.o_dwd_cmd !== 4'(i + 1)) begin errors++; $display("[TB] FAIL fill_cmd_beat%0d: got %0h want %0h", i, bus.o_dwd_cmd, i + 1); end
         checks++; if (bus.o_dwd_dat !== 32'h10 + 32'(i)) begin errors++; $display("[TB] FAIL fill_dat_beat%0d: got %0h want %0h", i, bus.o_dwd_dat, 32'h10 + 32'(i)); end
         checks++; if (bus.o_req_rdy !== 1'b1) begin errors++; $display("[TB] FAIL fill_rdy_beat%0d: got %0b want 1", i, bus.o_req_rdy); end
      end
      step();
      checks++; if (bus.o_dwd_vld !== 1'b0) begin errors++; $display("[TB] FAIL fill_vld_after: got %0b want 0", bus.o_dwd_vld); end
      checks++; if (bus.o_dwd_dat !== 32'h13) begin errors++; $display("[TB] FAIL fill_dat_hold: got %0h want 13", bus.o_dwd_dat); end
      checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL fill_busy_after: got %0b want 0", busy); end
   endtask

   // Beats from edges 0..3 pushes: gap=2 spacing gives beats after edges 2,5,8;
   // gap drops to 0 after edge 5, which only affects the spacing after the pop at edge 8.
   task automatic test_gap();
      logic expVld;
      int   beatIdx;
      enable = 1'b1;
      gap = 4'd2;
      beatIdx = 0;
      bus.i_req_vld = 1'b1;
      bus.i_req_cmd = 4'd8;
      bus.i_req_dat = 32'hC0;
      for (int k = 0; k < 12; k++) begin
         step();
         expVld = (k == 2) || (k == 5) || (k == 8) || (k == 9);
         checks++; if (bus.o_dwd_vld !== expVld) begin errors++; $display("[TB] FAIL gap_vld_e%0d: got %0b want %0b", k, bus.o_dwd_vld, expVld); end
         if (expVld) begin
            checks++; if (bus.o_dwd_cmd !== 4'(8 + beatIdx)) begin errors++; $display("[TB] FAIL gap_cmd_e%0d: got %0h want %0h", k, bus.o_dwd_cmd, 8 + beatIdx); end
            checks++; if (bus.o_dwd_dat !== 32'hC0 + 32'(beatIdx)) begin errors++; $display("[TB] FAIL gap_dat_e%0d: got %0h want %0h", k, bus.o_dwd_dat, 32'hC0 + 32'(beatIdx)); end
            beatIdx++;
         end
         if (k + 1 <= 3) begin
            bus.i_req_cmd = 4'(8 + k + 1);
            bus.i_req_dat = 32'hC0 + 32'(k + 1);
         end else begin
            bus.i_req_vld = 1'b0;
         end
         if (k == 5) gap = 4'd0;
      end
      checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL gap_busy_end: got %0b want 0", busy); end
   endtask

   task automatic test_flush();
      enable = 1'b0;
      gap = 4'd0;
      for (int i = 0; i < 3; i++) begin
         bus.i_req_vld = 1'b1;
         bus.i_req_cmd = 4'(1 + i);
         bus.i_req_dat = 32'hD0 + 32'(i);
         step();
      end
      checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL flush_busy_before: got %0b want 1", busy); end
      flush = 1'b1;
      bus.i_req_cmd = 4'd12;
      bus.i_req_dat = 32'hFF;
      step();
      flush = 1'b0;
      bus.i_req_vld = 1'b0;
      checks++; if (bus.o_dwd_vld !== 1'b0) begin errors++; $display("[TB] FAIL flush_vld: got %0b want 0", bus.o_dwd_vld); end
      checks++; if (bus.o_dwd_cmd !== 4'd0) begin errors++; $display("[TB] FAIL flush_cmd: got %0h want 0", bus.o_dwd_cmd); end
      checks++; if (bus.o_dwd_dat !== 32'hC3) begin errors++; $display("[TB] FAIL flush_dat_hold: got %0h want c3", bus.o_dwd_dat); end
      checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL flush_busy: got %0b want 0", busy); end
      checks++; if (bus.o_req_rdy !== 1'b1) begin errors++; $display("[TB] FAIL flush_rdy: got %0b want 1", bus.o_req_rdy); end
`ifdef AIXH_MXC_LEFT_DWD_DRV_BEATCNT_EN
      checks++; if (beatCnt !== 16'd0) begin errors++; $display("[TB] FAIL flush_beatcnt: got %0d want 0", beatCnt); end
`endif
      enable = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step();
         checks++; if (bus.o_dwd_vld !== 1'b0) begin errors++; $display("[TB] FAIL flush_empty_vld%0d: got %0b want 0", i, bus.o_dwd_vld); end
         checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL flush_empty_busy%0d: got %0b want 0", i, busy); end
      end
   endtask

   task automatic test_reset_mid();
      enable = 1'b0;
      gap = 4'd0;
      for (int i = 0; i < 3; i++) begin
         bus.i_req_vld = 1'b1;
         bus.i_req_cmd = 4'(4 + i);
         bus.i_req_dat = 32'hE0 + 32'(i);
         step();
      end
      bus.i_req_vld = 1'b0;
      enable = 1'b1;
      step();
      step();
      checks++; if (bus.o_dwd_vld !== 1'b1) begin errors++; $display("[TB] FAIL rstmid_first_vld: got %0b want 1", bus.o_dwd_vld); end
      checks++; if (bus.o_dwd_cmd !== 4'd4) begin errors++; $display("[TB] FAIL rstmid_first_cmd: got %0h want 4", bus.o_dwd_cmd); end
      reset = 1'b1;
      flush = 1'b1;
      bus.i_req_vld = 1'b1;
      step();
      flush = 1'b0;
      bus.i_req_vld = 1'b0;
      checks++; if (bus.o_dwd_vld !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_vld: got %0b want 0", bus.o_dwd_vld); end
      checks++; if (bus.o_dwd_cmd !== 4'd0) begin errors++; $display("[TB] FAIL rstmid_cmd: got %0h want 0", bus.o_dwd_cmd); end
      checks++; if (bus.o_dwd_dat !== 32'd0) begin errors++; $display("[TB] FAIL rstmid_dat: got %0h want 0", bus.o_dwd_dat); end
      checks++; if (bus.o_req_rdy !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_rdy: got %0b want 0", bus.o_req_rdy); end
      checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_busy: got %0b want 0", busy); end
      reset = 1'b0;
      #1;
      checks++; if (bus.o_req_rdy !== 1'b1) begin errors++; $display("[TB] FAIL rstmid_release_rdy: got %0b want 1", bus.o_req_rdy); end
      for (int i = 0; i < 4; i++) begin
         step();
         checks++; if (bus.o_dwd_vld !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_discard_vld%0d: got %0b want 0", i, bus.o_dwd_vld); end
         checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_discard_busy%0d: got %0b want 0", i, busy); end
      end
   endtask

`ifdef AIXH_MXC_LEFT_DWD_DRV_BEATCNT_EN
   // 3 beats first, then 65533 more so the counter wraps exactly to zero.
   task automatic test_beatcnt();
      enable = 1'b1;
      gap = 4'd0;
      checks++; if (beatCnt !== 16'd0) begin errors++; $display("[TB] FAIL beatcnt_start: got %0d want 0", beatCnt); end
      bus.i_req_vld = 1'b1;
      for (int i = 0; i < 3; i++) begin
         bus.i_req_cmd = 4'(i);
         step();
      end
      bus.i_req_vld = 1'b0;
      for (int i = 0; i < 5; i++) step();
      checks++; if (beatCnt !== 16'd3) begin errors++; $display("[TB] FAIL beatcnt_three: got %0d want 3", beatCnt); end
      bus.i_req_vld = 1'b1;
      for (int i = 0; i < 65533; i++) begin
         bus.i_req_cmd = 4'(i);
         step();
      end
      bus.i_req_vld = 1'b0;
      for (int i = 0; i < 5; i++) step();
      checks++; if (beatCnt !== 16'd0) begin errors++; $display("[TB] FAIL beatcnt_wrap: got %0d want 0", beatCnt); end
   endtask
`endif

   initial begin
      reset = 1'b1;
      enable = 1'b0;
      flush = 1'b0;
      gap = 4'd0;
      bus.i_req_vld = 1'b0;
      bus.i_req_cmd = '0;
      bus.i_req_dat = '0;
      @(negedge clock);
      test_reset();
      test_single();
      test_fill();
      test_gap();
      test_flush();
      test_reset_mid();
`ifdef AIXH_MXC_LEFT_DWD_DRV_BEATCNT_EN
      test_beatcnt();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #5000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
